// File: rtl/audio_stream_controller.sv
// Sample-rate scheduler: captures ADC pairs into an RX FIFO and plays TX FIFO pairs
// out through registered DAC outputs on each enabled advance strobe.
module audio_stream_controller #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 24
) (
  input  logic                     CLOCK_50,
  input  logic                     reset,
  input  logic                     advance,
  input  logic [WIDTH-1:0]         adc_left,
  input  logic [WIDTH-1:0]         adc_right,
  output logic [WIDTH-1:0]         dac_left,
  output logic [WIDTH-1:0]         dac_right,
  input  logic                     enable,
  input  logic                     mute,
  input  logic                     loopback,
  output logic                     rx_valid,
  input  logic                     rx_ready,
  output logic [WIDTH-1:0]         rx_left,
  output logic [WIDTH-1:0]         rx_right,
  input  logic                     tx_valid,
  output logic                     tx_ready,
  input  logic [WIDTH-1:0]         tx_left,
  input  logic [WIDTH-1:0]         tx_right,
  output logic [$clog2(DEPTH):0]   rx_count,
  output logic [$clog2(DEPTH):0]   tx_count,
  output logic [15:0]              overrun_count,
  output logic [15:0]              underrun_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [2*WIDTH-1:0] rx_mem [DEPTH];
  logic [2*WIDTH-1:0] tx_mem [DEPTH];

  logic [AW-1:0]    rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [AW-1:0]    tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  logic [CW-1:0]    rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
  logic [WIDTH-1:0] dac_l_q, dac_l_d, dac_r_q, dac_r_d;
  logic [15:0]      ovr_q, ovr_d, und_q, und_d;

  logic sample_ev, rx_push, rx_pop, tx_wr, tx_pop, underrun;
  logic [2*WIDTH-1:0] tx_head;

  // Full/empty decisions use the count at the start of the cycle, so a
  // same-cycle consumer read never makes room for a capture.
  assign sample_ev = advance & enable;
  assign rx_push   = sample_ev & (rx_cnt_q != FULL);
  assign rx_pop    = rx_valid & rx_ready;
  assign tx_wr     = tx_valid & tx_ready;
  assign tx_pop    = sample_ev & ~loopback & (tx_cnt_q != '0);
  assign underrun  = sample_ev & ~loopback & (tx_cnt_q == '0);
  assign tx_head   = tx_mem[tx_rp_q];

  assign rx_valid       = (rx_cnt_q != '0);
  assign tx_ready       = enable & ~reset & (tx_cnt_q != FULL);
  assign rx_left        = rx_valid ? rx_mem[rx_rp_q][2*WIDTH-1:WIDTH] : '0;
  assign rx_right       = rx_valid ? rx_mem[rx_rp_q][WIDTH-1:0]       : '0;
  assign dac_left       = dac_l_q;
  assign dac_right      = dac_r_q;
  assign rx_count       = rx_cnt_q;
  assign tx_count       = tx_cnt_q;
  assign overrun_count  = ovr_q;
  assign underrun_count = und_q;

  always_comb begin
    rx_wp_d  = rx_wp_q;
    rx_rp_d  = rx_rp_q;
    rx_cnt_d = rx_cnt_q;
    tx_wp_d  = tx_wp_q;
    tx_rp_d  = tx_rp_q;
    tx_cnt_d = tx_cnt_q;
    dac_l_d  = dac_l_q;
    dac_r_d  = dac_r_q;
    ovr_d    = ovr_q;
    und_d    = und_q;
    if (!enable) begin
      rx_wp_d  = '0;
      rx_rp_d  = '0;
      rx_cnt_d = '0;
      tx_wp_d  = '0;
      tx_rp_d  = '0;
      tx_cnt_d = '0;
      dac_l_d  = '0;
      dac_r_d  = '0;
    end else begin
      if (rx_push) rx_wp_d = rx_wp_q + AW'(1);
      if (rx_pop)  rx_rp_d = rx_rp_q + AW'(1);
      rx_cnt_d = rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
      if (tx_wr)   tx_wp_d = tx_wp_q + AW'(1);
      if (tx_pop)  tx_rp_d = tx_rp_q + AW'(1);
      tx_cnt_d = tx_cnt_q + CW'(tx_wr) - CW'(tx_pop);
      if (sample_ev) begin
        if (mute) begin
          dac_l_d = '0;
          dac_r_d = '0;
        end else if (loopback) begin
          dac_l_d = adc_left;
          dac_r_d = adc_right;
        end else if (tx_pop) begin
          dac_l_d = tx_head[2*WIDTH-1:WIDTH];
          dac_r_d = tx_head[WIDTH-1:0];
        end else begin
          dac_l_d = '0;
          dac_r_d = '0;
        end
        if (!rx_push && ovr_q != 16'hFFFF) ovr_d = ovr_q + 16'd1;
        if (underrun && und_q != 16'hFFFF) und_d = und_q + 16'd1;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      rx_wp_q  <= '0;
      rx_rp_q  <= '0;
      rx_cnt_q <= '0;
      tx_wp_q  <= '0;
      tx_rp_q  <= '0;
      tx_cnt_q <= '0;
      dac_l_q  <= '0;
      dac_r_q  <= '0;
      ovr_q    <= '0;
      und_q    <= '0;
    end else begin
      rx_wp_q  <= rx_wp_d;
      rx_rp_q  <= rx_rp_d;
      rx_cnt_q <= rx_cnt_d;
      tx_wp_q  <= tx_wp_d;
      tx_rp_q  <= tx_rp_d;
      tx_cnt_q <= tx_cnt_d;
      dac_l_q  <= dac_l_d;
      dac_r_q  <= dac_r_d;
      ovr_q    <= ovr_d;
      und_q    <= und_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by the counters.
  always_ff @(posedge CLOCK_50) begin
    if (rx_push && !reset) rx_mem[rx_wp_q] <= {adc_left, adc_right};
    if (tx_wr)             tx_mem[tx_wp_q] <= {tx_left, tx_right};
  end
endmodule
